serial_inst_loader: RTL and testbench

Parametrised successor to the single-word serial instruction receiver. Deserialises a bit stream clocked by an external, asynchronous `sclk` into WORD_W-bit words. Writes each completed word into instruction RAM at an auto-incrementing address.
- Sits between the chip pins (`IWEN`/`sclk`/`wInst`) and the instruction RAM write port.
- Replaces the external address counter and the edge-detect glue around it.
- Adds session control, a full/overflow indication and configurable bit order.

---
 rtl/serial_inst_loader_pkg.sv | 15 +
 rtl/serial_inst_loader_sync_edge.sv | 37 +++
 rtl/serial_inst_loader.sv | 198 +++++++++++++++++++
 tb/tb_serial_inst_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_inst_loader_pkg.sv
// Shared definitions for the serial instruction loader and the instruction
// RAM instances it feeds: default geometry and the loader state encoding.
package serial_inst_loader_pkg;

  // Default word width and word-address width, shared with the RAM instances.
  localparam int DEF_WORD_W = 32;
  localparam int DEF_ADDR_W = 7;

  // Loader session state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_FULL  = 2'd2;

endpackage

// File: rtl/serial_inst_loader_sync_edge.sv
// sync_edge: multi-flop synchroniser for the raw serial clock, with the serial
// data synchronised alongside through an identical chain so both arrive on the
// same clk edge. Produces a one-cycle pulse on each synced sclk rise.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic sdata,
  output logic rise,
  output logic sdata_sync
);

  logic [SYNC_STAGES-1:0] sclk_chain;
  logic [SYNC_STAGES-1:0] sdata_chain;
  logic                   sclk_dly;

  // Synchroniser chains plus one delayed copy of synced sclk for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_chain  <= '0;
      sdata_chain <= '0;
      sclk_dly    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value of
      // its predecessor, which is what makes this a chain rather than a wire.
      sclk_chain  <= {sclk_chain[SYNC_STAGES-2:0], sclk};
      sdata_chain <= {sdata_chain[SYNC_STAGES-2:0], sdata};
      sclk_dly    <= sclk_chain[SYNC_STAGES-1];
    end
  end

  assign rise       = sclk_chain[SYNC_STAGES-1] & ~sclk_dly;
  assign sdata_sync = sdata_chain[SYNC_STAGES-1];

endmodule

// File: rtl/serial_inst_loader.sv
// serial_inst_loader: deserialises an sclk-clocked bit stream into words and
// writes them to instruction RAM at an auto-incrementing address, with session
// control, full/overflow indication and selectable bit order.
// Optional build macro SER_PARITY_EN: each word is followed by an even-parity
// bit; bad words are not written and raise the sticky parity_err output.
module serial_inst_loader
  import serial_inst_loader_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SYNC_STAGES = 2,
  parameter int LSB_FIRST   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              sclk,
  input  logic              sdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   word_cnt,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef SER_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef SER_PARITY_EN
  localparam int LAST_BIT = WORD_W;      // data bits then one parity bit
`else
  localparam int LAST_BIT = WORD_W - 1;
`endif
  localparam int BC_W = $clog2(LAST_BIT + 1);

  state_t            state;
  logic              load_en_q;
  logic [BC_W-1:0]   bitcnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] shreg_next;
  logic [WORD_W-1:0] hold;
  logic              pending;

  logic sclk_rise;
  logic sdata_s;
  logic start;
  logic session_end;
  logic shift_en;
  logic word_last;
  logic word_done;
  logic issue;
  logic data_bit;
  logic word_ok;
  logic [WORD_W-1:0] word_val;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .sdata     (sdata),
    .rise      (sclk_rise),
    .sdata_sync(sdata_s)
  );

  assign start       = load_en & ~load_en_q & (state == ST_IDLE);
  assign session_end = (state != ST_IDLE) & ~load_en;
  assign shift_en    = sclk_rise & (state != ST_IDLE) & load_en;
  assign word_last   = (bitcnt == BC_W'(LAST_BIT));
  assign word_done   = shift_en & word_last;
  // The write for a pending word never overlaps the previous write, so the
  // address has always advanced before the next word goes out.
  assign issue       = (state == ST_SHIFT) & pending & ~mem_we;
  assign busy        = (state != ST_IDLE);

`ifdef SER_PARITY_EN
  // The last bit is parity: it is not shifted in, and the word is already
  // complete in shreg when it arrives.
  assign data_bit = ~word_last;
  assign word_ok  = ((^shreg) == sdata_s);
  assign word_val = shreg;
`else
  assign data_bit = 1'b1;
  assign word_ok  = 1'b1;
  assign word_val = shreg_next;
`endif

  // Next shift-register value for the sample arriving on this edge.
  always_comb begin
    // NOTE: default first, so every path assigns shreg_next and no latch forms.
    shreg_next = shreg;
    if (LSB_FIRST != 0) begin
      for (int i = 0; i < WORD_W; i++) begin
        if (bitcnt == BC_W'(i)) shreg_next[i] = sdata_s;
      end
    end else begin
      shreg_next = {shreg[WORD_W-2:0], sdata_s};
    end
  end

  // Bit assembly: runs regardless of the write cycle so no bits are lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt  <= '0;
      shreg   <= '0;
      hold    <= '0;
      pending <= 1'b0;
    end else if (start || session_end) begin
      bitcnt  <= '0;
      shreg   <= '0;
      pending <= 1'b0;
    end else begin
      if (issue || state == ST_FULL) pending <= 1'b0;
      if (shift_en) begin
        if (data_bit) shreg <= shreg_next;
        if (word_last) begin
          bitcnt <= '0;
          if (word_ok && state == ST_SHIFT) begin
            hold    <= word_val;
            pending <= 1'b1;
          end
        end else begin
          bitcnt <= bitcnt + BC_W'(1);
        end
      end
    end
  end

  // Session FSM, RAM write strobe, address/count advance and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      load_en_q <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      word_cnt  <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
`ifdef SER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      load_en_q <= load_en;
      mem_we    <= 1'b0;

      // Address and count advance the cycle after each write.
      if (mem_we) begin
        mem_waddr <= mem_waddr + ADDR_W'(1);
        word_cnt  <= word_cnt + (ADDR_W + 1)'(1);
      end

`ifdef SER_PARITY_EN
      if (word_done && !word_ok) parity_err <= 1'b1;
`endif

      case (state)
        ST_IDLE: begin
          if (start) begin
            mem_waddr <= '0;
            word_cnt  <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
`ifdef SER_PARITY_EN
            parity_err <= 1'b0;
`endif
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (issue) begin
            mem_we    <= 1'b1;
            mem_wdata <= hold;
          end
          if (mem_we && word_cnt == (ADDR_W + 1)'(DEPTH - 1)) state <= ST_FULL;
          if (!load_en) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        ST_FULL: begin
          if (word_done || pending) overflow <= 1'b1;
          if (!load_en) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_inst_loader.sv
// Self-checking bench for serial_inst_loader. Two instances share one serial
// stream: a default build (LSB first, 128 words) and a small MSB-first build
// (4 words) that exercises FULL/overflow. Expected writes are queued when a
// word is sent and compared when the corresponding mem_we pulse appears.
module tb_serial_inst_loader;

  logic clk = 1'b0;
  logic rst;
  logic load_en;
  logic sclk;
  logic sdata;

  logic        a_mem_we, a_busy, a_done, a_overflow;
  logic [6:0]  a_mem_waddr;
  logic [31:0] a_mem_wdata;
  logic [7:0]  a_word_cnt;

  logic        b_mem_we, b_busy, b_done, b_overflow;
  logic [1:0]  b_mem_waddr;
  logic [31:0] b_mem_wdata;
  logic [2:0]  b_word_cnt;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t q_a[$];
  wr_t q_b[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  a_cnt   = 0;
  int  b_cnt   = 0;

  always #5 clk = ~clk;

  serial_inst_loader dut_a (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .sclk     (sclk),
    .sdata    (sdata),
    .mem_we   (a_mem_we),
    .mem_waddr(a_mem_waddr),
    .mem_wdata(a_mem_wdata),
    .word_cnt (a_word_cnt),
    .busy     (a_busy),
    .done     (a_done),
    .overflow (a_overflow)
  );

  serial_inst_loader #(
    .ADDR_W   (2),
    .LSB_FIRST(0)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .sclk     (sclk),
    .sdata    (sdata),
    .mem_we   (b_mem_we),
    .mem_waddr(b_mem_waddr),
    .mem_wdata(b_mem_wdata),
    .word_cnt (b_word_cnt),
    .busy     (b_busy),
    .done     (b_done),
    .overflow (b_overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = v[i];
    return r;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bit i of v is sent i-th; each sclk phase lasts the minimum 3 clk cycles.
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      sdata = v[i];
      wait_clk(3);
      sclk = 1'b1;
      wait_clk(3);
      sclk = 1'b0;
    end
  endtask

  // Queue the expected writes for both instances, then send the word.
  task automatic send_word(input logic [31:0] v);
    wr_t e;
    e.addr = a_cnt % 128;
    e.data = v;
    q_a.push_back(e);
    a_cnt++;
    if (b_cnt < 4) begin
      e.addr = b_cnt;
      e.data = rev32(v);
      q_b.push_back(e);
    end
    b_cnt++;
    send_bits(v, 32);
  endtask

  task automatic start_session();
    a_cnt   = 0;
    b_cnt   = 0;
    load_en = 1'b1;
    wait_clk(3);
  endtask

  // Write monitors for each instance.
  always @(negedge clk) begin
    wr_t e;
    if (a_mem_we === 1'b1) begin
      check("a_we_expected", 64'(q_a.size() != 0), 64'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("a_waddr", 64'(a_mem_waddr), 64'(e.addr));
        check("a_wdata", 64'(a_mem_wdata), 64'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (b_mem_we === 1'b1) begin
      check("b_we_expected", 64'(q_b.size() != 0), 64'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("b_waddr", 64'(b_mem_waddr), 64'(e.addr));
        check("b_wdata", 64'(b_mem_wdata), 64'(e.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    load_en = 1'b0;
    sclk    = 1'b0;
    sdata   = 1'b0;
    wait_clk(3);
    check("rst_we",    64'(a_mem_we),    64'd0);
    check("rst_waddr", 64'(a_mem_waddr), 64'd0);
    check("rst_wdata", 64'(a_mem_wdata), 64'd0);
    check("rst_cnt",   64'(a_word_cnt),  64'd0);
    check("rst_busy",  64'(a_busy),      64'd0);
    check("rst_done",  64'(a_done),      64'd0);
    check("rst_ovf",   64'(a_overflow),  64'd0);
    rst = 1'b0;
    wait_clk(2);

    // Session 1: a single word.
    start_session();
    check("s1_busy", 64'(a_busy), 64'd1);
    send_word(32'h0000_0013);
    wait_clk(10);
    check("s1_a_cnt", 64'(a_word_cnt), 64'd1);
    check("s1_b_cnt", 64'(b_word_cnt), 64'd1);
    check("s1_qa_drained", 64'(q_a.size()), 64'd0);
    load_en = 1'b0;
    wait_clk(3);
    check("s1_done", 64'(a_done), 64'd1);
    check("s1_idle", 64'(a_busy), 64'd0);

    // Session 2: back-to-back words, small instance fills then overflows.
    start_session();
    check("s2_done_clr", 64'(a_done), 64'd0);
    send_word(32'hDEAD_BEEF);
    send_word(32'h1234_5678);
    send_word(32'h0000_0000);
    send_word(32'h8000_0001);
    wait_clk(10);
    check("s2_b_cnt4",    64'(b_word_cnt), 64'd4);
    check("s2_b_waddr",   64'(b_mem_waddr), 64'd0);
    check("s2_b_ovf_no",  64'(b_overflow), 64'd0);
    send_word(32'h0000_0055);
    wait_clk(10);
    check("s2_a_cnt",     64'(a_word_cnt), 64'd5);
    check("s2_a_waddr",   64'(a_mem_waddr), 64'd5);
    check("s2_a_ovf",     64'(a_overflow), 64'd0);
    check("s2_b_cnt",     64'(b_word_cnt), 64'd4);
    check("s2_b_ovf",     64'(b_overflow), 64'd1);
    check("s2_b_busy",    64'(b_busy), 64'd1);

    // Partial word then session end: nothing written.
    send_bits(32'hFFFF_FFFF, 10);
    load_en = 1'b0;
    wait_clk(5);
    check("s2_end_done",  64'(a_done), 64'd1);
    check("s2_end_busy",  64'(a_busy), 64'd0);
    check("s2_end_cnt",   64'(a_word_cnt), 64'd5);

    // Session 3: restart clears state, then reset mid-word.
    start_session();
    check("s3_b_ovf_clr", 64'(b_overflow), 64'd0);
    check("s3_b_waddr",   64'(b_mem_waddr), 64'd0);
    check("s3_a_cnt",     64'(a_word_cnt), 64'd0);
    check("s3_a_done",    64'(a_done), 64'd0);
    send_bits(32'hCAFE_F00D, 20);
    sclk  = 1'b1;
    sdata = 1'b1;
    wait_clk(1);
    rst     = 1'b1;
    load_en = 1'b0;
    #1;
    check("mid_rst_busy",  64'(a_busy),      64'd0);
    check("mid_rst_wdata", 64'(a_mem_wdata), 64'd0);
    check("mid_rst_cnt",   64'(b_word_cnt),  64'd0);
    check("mid_rst_ovf",   64'(b_overflow),  64'd0);
    check("mid_rst_waddr", 64'(a_mem_waddr), 64'd0);
    sclk = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);

    // Session 4: clean load after reset.
    start_session();
    send_word(32'hA5A5_0F0F);
    wait_clk(10);
    check("s4_a_cnt", 64'(a_word_cnt), 64'd1);
    check("s4_b_cnt", 64'(b_word_cnt), 64'd1);
    load_en = 1'b0;
    wait_clk(5);

    check("end_qa_empty", 64'(q_a.size()), 64'd0);
    check("end_qb_empty", 64'(q_b.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
